// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared formats, opcodes and entry sizing for the immediate generator
package imm_gen_pkg;
  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd7
  } imm_fmt_e;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  function automatic int entry_w(int xlen);
    return xlen + 4;
  endfunction
endpackage

// File: rtl/imm_fifo.sv
// imm_fifo: DEPTH-entry FIFO with flush; head reads zero when empty
module imm_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop) rptr <= inc(rptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wptr] <= wdata;
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes and sign-extends RV immediates into a buffered output queue
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output imm_fmt_e         fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be a power of two");
  end
  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } imm_entry_t;
  imm_entry_t  dec, head;
  logic [31:0] imm32;
  logic        full, empty, push, pop;
  // every format fits in 32 bits sign-extended, so widen once at the end
  always_comb begin
    imm32       = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (inst[6:0])
      OP_IMM, OP_IMM32, LOAD: begin
        dec.fmt = FMT_I;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      JALR: begin
        dec.fmt     = inst[14:12] == 3'b000 ? FMT_I : FMT_NONE;
        dec.illegal = inst[14:12] != 3'b000;
        imm32       = inst[14:12] == 3'b000 ? {{20{inst[31]}}, inst[31:20]} : '0;
      end
      STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {inst[31:12], 12'b0};
      end
      JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  imm_fifo #(.DEPTH(DEPTH), .W(entry_w(XLEN))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign imm     = head.imm;
  assign fmt     = empty ? FMT_NONE : head.fmt;
  assign illegal = head.illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_cnt <= '0;
    else if (push && !flush && dec.illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe at XLEN=64 with a shadow XLEN=32 instance
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic        in_ready, out_valid, illegal;
  logic [63:0] imm;
  imm_fmt_e    fmt;
  logic [15:0] illegal_cnt;
  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  imm_fmt_e    fmt32;
  logic [1:0]  cnt32;
  typedef struct {
    logic [63:0] imm;
    imm_fmt_e    fmt;
    logic        ill;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt),
    .illegal(illegal), .illegal_cnt(illegal_cnt));
  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .fmt(fmt32),
    .illegal(illegal32), .illegal_cnt(cnt32));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got imm %h expected no output", imm);
      end else begin
        e = q.pop_front();
        chk("imm", imm, e.imm);
        chk("fmt", 64'(fmt), 64'(e.fmt));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
      end
    end

  task automatic send(logic [31:0] w, logic [63:0] ei, imm_fmt_e ef, logic el);
    int k = 0;
    inst = w;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      in_valid = 1'b0;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else q.push_back('{ei, ef, el});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt", 64'(illegal_cnt), 64'd0);
    chk("rst_imm", imm, 64'd0);
    chk("rst_fmt", 64'(fmt), 64'(FMT_NONE));
    chk("rst_illegal", 64'(illegal), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    send(32'hFE20AE23, 64'hFFFFFFFFFFFFFFFC, FMT_S, 1'b0);
    send(32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, FMT_B, 1'b0);
    send(32'h00000463, 64'h0000000000000008, FMT_B, 1'b0);
    send(32'h800002B7, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
    send(32'h12345297, 64'h0000000012345000, FMT_U, 1'b0);
    send(32'h0010006F, 64'h0000000000000800, FMT_J, 1'b0);
    send(32'h8001009B, 64'hFFFFFFFFFFFFF800, FMT_I, 1'b0);
    send(32'h7FF0B083, 64'h00000000000007FF, FMT_I, 1'b0);
    send(32'hFF0080E7, 64'hFFFFFFFFFFFFFFF0, FMT_I, 1'b0);
    send(32'h000090E7, 64'h0, FMT_NONE, 1'b1);
    send(32'h00000033, 64'h0, FMT_NONE, 1'b1);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
    chk("cnt_stream", 64'(illegal_cnt), 64'd2);
    chk("cnt32_stream", 64'(cnt32), 64'd2);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    send(32'h0, 64'h0, FMT_NONE, 1'b1);
    send(32'h0, 64'h0, FMT_NONE, 1'b1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_cnt", 64'(illegal_cnt), 64'd2);
    chk("head_illegal", 64'(illegal), 64'd1);
    chk("head_imm", imm, 64'd0);
    chk("head_fmt", 64'(fmt), 64'(FMT_NONE));
    inst = 32'h0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("blocked_in_ready", 64'(in_ready), 64'd0);
    chk("blocked_cnt", 64'(illegal_cnt), 64'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_cnt", 64'(illegal_cnt), 64'd2);
    chk("flush_fmt", 64'(fmt), 64'(FMT_NONE));
    flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop_valid", 64'(out_valid), 64'd0);
    chk("flush_drop_cnt", 64'(illegal_cnt), 64'd2);
    chk("flush_drop_cnt32", 64'(cnt32), 64'd2);
    send(32'h00000033, 64'h0, FMT_NONE, 1'b1);
    chk("cnt32_max", 64'(cnt32), 64'd3);
    send(32'h000090E7, 64'h0, FMT_NONE, 1'b1);
    chk("cnt_refill", 64'(illegal_cnt), 64'd4);
    chk("cnt32_sat", 64'(cnt32), 64'd3);
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_pop_in_ready", 64'(in_ready), 64'd1);
    chk("after_pop_q", 64'(q.size()), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst_cnt", 64'(illegal_cnt), 64'd0);
    chk("async_rst_cnt32", 64'(cnt32), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, buffered immediate generator for the RV decode stage.
- Accepts 32-bit instruction words over a valid/ready handshake.
- Decodes the immediate format from opcode/funct3 and sign-extends to XLEN.
- Queues {imm, fmt, illegal} in a DEPTH-entry FIFO toward execute.
- Adds explicit handling for B-type, AUIPC, OP-IMM-32 and illegal encodings, a synchronous flush, and a saturating illegal-instruction counter.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; any other value is an elaboration error.
DEPTH, 2, output FIFO entries; power of two, ≥1.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous flush; empties the FIFO.
in_valid  in  1  instruction word is valid.
in_ready  out  1  block can accept a word; equals !full.
inst  in  32  raw instruction word.
out_valid  out  1  FIFO not empty.
out_ready  in  1  consumer accepts the head entry.
imm  out  XLEN  sign-extended immediate at the FIFO head.
fmt  out  3  format at the FIFO head (imm_fmt_e).
illegal  out  1  head entry came from an unsupported encoding.
illegal_cnt  out  CNT_W  saturating count of accepted illegal words.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO pointers and count = 0.
  - out_valid=0, in_ready=1, illegal_cnt=0.
  - imm=0, fmt=FMT_NONE, illegal=0. Head outputs read 0 / FMT_NONE whenever the FIFO is empty.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Latency: a word pushed in cycle N is visible at the head (out_valid=1) in cycle N+1 if the FIFO was empty. There is no combinational input-to-output path.
- in_ready = (count < DEPTH). It is not pop-aware. When full with a pop in the same cycle, in_ready stays 0 that cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- flush=1: the next edge sets pointers and count to 0. A push in the same cycle is dropped and not counted. flush has priority over push and pop.
- Decode (combinational, before the FIFO write). Sign bit is always inst[31]; extension fills to XLEN.
  - 0010011, 0011011, 0000011: FMT_I; imm = inst[31:20].
  - 1100111 with funct3=000 (JALR): FMT_I; imm = inst[31:20].
  - 1100111 with funct3≠000: illegal.
  - 0100011: FMT_S; imm = {inst[31:25], inst[11:7]}.
  - 1100011: FMT_B; imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - 0110111, 0010111: FMT_U; imm = {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - 1101111: FMT_J; imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Any other opcode: fmt=FMT_NONE, imm=0, illegal=1.
- illegal_cnt increments by 1 on each accepted push with illegal=1 and saturates at all-ones. It is not cleared by flush, only by reset.
- Reset asserted mid-operation discards all queued entries immediately, with no handshake completion.

Decomposition:
- Package imm_gen_pkg holds:
  - typedef enum logic [2:0] imm_fmt_e: FMT_I=0, FMT_S=1, FMT_B=2, FMT_U=3, FMT_J=4, FMT_NONE=7.
  - opcode localparams: OP_IMM, OP_IMM32, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC.
  - packed struct imm_entry_t {imm, fmt, illegal}, with imm sized by a package function or a parametrised struct in the top module.
- One sub-module: imm_fifo (parametrised by DEPTH and entry width) holds pointers, count and storage.
- The decoder stays as a combinational function/always_comb in imm_gen_pipe.

Test Plan:
- XLEN=64, inst=0xFFF00093 (addi x1,x0,-1) pushed into an empty FIFO -> next cycle out_valid=1, imm=0xFFFFFFFFFFFFFFFF, fmt=FMT_I, illegal=0.
- inst=0xFE20AE23 (sw offset -4) -> imm=0xFFFFFFFFFFFFFFFC, fmt=FMT_S.
- inst=0xFE000CE3 (beq -8) -> imm=0xFFFFFFFFFFFFFFF8, fmt=FMT_B.
- inst=0x800002B7 (lui):
  - XLEN=64 -> imm=0xFFFFFFFF80000000, fmt=FMT_U.
  - XLEN=32 -> imm=0x80000000.
- inst=0x0010006F (jal +2048) -> imm=0x800, fmt=FMT_J.
- Back-to-back push of 0x00000000 three times with out_ready=0, DEPTH=2:
  - First two accepted; in_ready=0 from the cycle after the second push.
  - illegal_cnt=2; head entry has illegal=1, imm=0, fmt=FMT_NONE.
  - Then assert flush with in_valid=1 -> out_valid=0 next cycle, illegal_cnt stays 2.
  - Then assert rst_n=0 mid-cycle -> illegal_cnt=0 immediately.
